// File: rtl/sram_ctrl_pkg.sv
// Shared types for the SRAM front-end: FSM state encoding and wait-counter width.
package sram_ctrl_pkg;

  localparam int unsigned WAIT_W = 4;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WR_SETUP  = 3'd1,
    WR_PULSE  = 3'd2,
    WR_HOLD   = 3'd3,
    RD_ACCESS = 3'd4,
    RD_DONE   = 3'd5
  } state_t;

endpackage

// File: rtl/sram_io_buf.sv
// Tri-state driver for the SRAM data bus plus the registered read-data capture path.
module sram_io_buf #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              oe,
  input  logic [DATA_W-1:0] wdata,
  input  logic              capture,
  output logic [DATA_W-1:0] rdata,
  inout  wire  [DATA_W-1:0] sram_data
);

  assign sram_data = oe ? wdata : {DATA_W{1'bz}};

  // rdata holds its value until the next completed read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (capture) begin
      rdata <= sram_data;
    end
  end

endmodule

// File: rtl/sram_ctrl.sv
// Synchronous valid/ready front-end that sequences registered strobes for an asynchronous SRAM.
module sram_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              ready,
  output logic [DATA_W-1:0] rdata,
  output logic              rd_valid,
  output logic [ADDR_W-1:0] sram_addr,
  inout  wire  [DATA_W-1:0] sram_data,
  output logic              sram_oe_n,
  output logic              sram_we_n
);

  localparam logic [WAIT_W-1:0] WAIT_LD = WAIT_W'(WAIT_CYCLES);

  state_t            state;
  logic [WAIT_W-1:0] cnt;
  logic [DATA_W-1:0] wdata_q;
  logic              drive_en;
  logic              capture_c;

  // Sample the bus on the edge that leaves RD_ACCESS
  assign capture_c = (state == RD_ACCESS) && (cnt == '0);

  sram_io_buf #(.DATA_W(DATA_W)) u_io (
    .clk       (clk),
    .rst_n     (rst_n),
    .oe        (drive_en),
    .wdata     (wdata_q),
    .capture   (capture_c),
    .rdata     (rdata),
    .sram_data (sram_data)
  );

  // Access sequencer; every strobe and the bus driver enable are registered here
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ready     <= 1'b1;
      rd_valid  <= 1'b0;
      sram_addr <= '0;
      sram_oe_n <= 1'b1;
      sram_we_n <= 1'b1;
      drive_en  <= 1'b0;
      cnt       <= '0;
      wdata_q   <= '0;
    end else begin
      rd_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            ready     <= 1'b0;
            sram_addr <= addr;
            if (we) begin
              wdata_q  <= wdata;
              drive_en <= 1'b1;
              state    <= WR_SETUP;
            end else begin
              sram_oe_n <= 1'b0;
              cnt       <= WAIT_LD;
              state     <= RD_ACCESS;
            end
          end
        end
        WR_SETUP: begin
          sram_we_n <= 1'b0;
          cnt       <= WAIT_LD;
          state     <= WR_PULSE;
        end
        WR_PULSE: begin
          if (cnt == '0) begin
            sram_we_n <= 1'b1;
            state     <= WR_HOLD;
          end else begin
            cnt <= cnt - WAIT_W'(1);
          end
        end
        WR_HOLD: begin
          drive_en <= 1'b0;
          ready    <= 1'b1;
          state    <= IDLE;
        end
        RD_ACCESS: begin
          if (cnt == '0) begin
            sram_oe_n <= 1'b1;
            rd_valid  <= 1'b1;
            state     <= RD_DONE;
          end else begin
            cnt <= cnt - WAIT_W'(1);
          end
        end
        RD_DONE: begin
          ready <= 1'b1;
          state <= IDLE;
        end
        default: begin
          ready     <= 1'b1;
          sram_oe_n <= 1'b1;
          sram_we_n <= 1'b1;
          drive_en  <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_ctrl.sv
// Randomized self-checking bench for sram_ctrl with a behavioural asynchronous SRAM and reference memory.
module tb_sram_ctrl;

  localparam int unsigned ADDR_W = 10;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned WAIT   = 1;
  localparam int unsigned DEPTH  = 1 << ADDR_W;
  localparam int          TMO    = 64;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              req = 1'b0;
  logic              we = 1'b0;
  logic [ADDR_W-1:0] addr = '0;
  logic [DATA_W-1:0] wdata = '0;
  logic              ready;
  logic [DATA_W-1:0] rdata;
  logic              rd_valid;
  logic [ADDR_W-1:0] sram_addr;
  wire  [DATA_W-1:0] sram_data;
  logic              sram_oe_n;
  logic              sram_we_n;

  // Behavioural asynchronous SRAM
  logic [DATA_W-1:0] mem [DEPTH];
  assign sram_data = (!sram_oe_n) ? mem[sram_addr] : {DATA_W{1'bz}};

  // Reference model state
  logic [DATA_W-1:0] ref_mem [DEPTH];
  logic [DATA_W-1:0] exp_q [$];
  logic [DATA_W-1:0] exp_v;
  logic              alt_ok = 1'b0;
  logic [DATA_W-1:0] alt_val = '0;

  int checks = 0;
  int failures = 0;
  int we_lo = 0;
  int oe_lo = 0;
  int rdv_cnt = 0;

  always #5 clk = ~clk;

  sram_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WAIT_CYCLES(WAIT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .we        (we),
    .addr      (addr),
    .wdata     (wdata),
    .ready     (ready),
    .rdata     (rdata),
    .rd_valid  (rd_valid),
    .sram_addr (sram_addr),
    .sram_data (sram_data),
    .sram_oe_n (sram_oe_n),
    .sram_we_n (sram_we_n)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // SRAM write, protocol monitor and read-data scoreboard
  always @(negedge clk) begin
    if (!sram_we_n) mem[sram_addr] = sram_data;
    if (rst_n) begin
      if (!sram_we_n) we_lo++;
      if (!sram_oe_n) oe_lo++;
      if (!sram_we_n || !sram_oe_n)
        check("strobe_excl", 32'(sram_we_n | sram_oe_n), 32'd1);
      if (!sram_oe_n)
        check("oe_vs_drive", 32'(dut.drive_en), 32'd0);
      if (rd_valid) begin
        rdv_cnt++;
        if (exp_q.size() == 0) begin
          check("rdv_unexpected", 32'd1, 32'd0);
        end else begin
          exp_v = exp_q.pop_front();
          if (alt_ok && rdata == alt_val) exp_v = alt_val;
          alt_ok = 1'b0;
          check("rdata", 32'(rdata), 32'(exp_v));
        end
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!ready && n < TMO) begin
      @(negedge clk);
      n++;
    end
    if (!ready) check("ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_busy_done(output int n);
    n = 0;
    while (n < TMO) begin
      @(posedge clk);
      n++;
      #1;
      if (ready) break;
    end
  endtask

  task automatic access(input bit w, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    int n;
    @(negedge clk);
    wait_ready();
    req = 1'b1; we = w; addr = a; wdata = d;
    @(posedge clk);
    #1;
    req = 1'b0;
    we_lo = 0; oe_lo = 0; rdv_cnt = 0;
    if (w) ref_mem[a] = d;
    else exp_q.push_back(ref_mem[a]);
    check("ready_drop", 32'(ready), 32'd0);
    wait_busy_done(n);
    check(w ? "wr_latency" : "rd_latency", 32'(n), w ? 32'(3 + WAIT) : 32'(2 + WAIT));
    @(negedge clk);
    check("we_low_cycles", 32'(we_lo), w ? 32'(1 + WAIT) : 32'd0);
    check("oe_low_cycles", 32'(oe_lo), w ? 32'd0 : 32'(1 + WAIT));
    check("rd_valid_pulses", 32'(rdv_cnt), w ? 32'd0 : 32'd1);
  endtask

  initial begin
    int n;
    logic [ADDR_W-1:0] ra;
    for (int i = 0; i < int'(DEPTH); i++) begin
      mem[i] = '0;
      ref_mem[i] = '0;
    end

    // Reset values
    #12;
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_rd_valid", 32'(rd_valid), 32'd0);
    check("rst_rdata", 32'(rdata), 32'd0);
    check("rst_sram_addr", 32'(sram_addr), 32'd0);
    check("rst_oe_n", 32'(sram_oe_n), 32'd1);
    check("rst_we_n", 32'(sram_we_n), 32'd1);
    check("rst_drive", 32'(dut.drive_en), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic write/read
    access(1'b1, 10'h001, 8'hA5);
    access(1'b0, 10'h001, 8'h00);

    // Address extremes
    access(1'b1, 10'h3FF, 8'hFF);
    access(1'b1, 10'h000, 8'h00);
    access(1'b0, 10'h3FF, 8'h00);
    access(1'b0, 10'h000, 8'h00);

    // req held high across a write and a following read
    @(negedge clk);
    wait_ready();
    req = 1'b1; we = 1'b1; addr = 10'h002; wdata = 8'h3C;
    @(posedge clk);
    #1;
    ref_mem[10'h002] = 8'h3C;
    exp_q.push_back(8'h3C);
    we = 1'b0;
    we_lo = 0; oe_lo = 0; rdv_cnt = 0;
    wait_busy_done(n);
    check("b2b_wr_latency", 32'(n), 32'(3 + WAIT));
    check("b2b_idle_gap", 32'({sram_we_n, sram_oe_n}), 32'd3);
    @(posedge clk);
    #1;
    check("b2b_accept", 32'(ready), 32'd0);
    req = 1'b0;
    wait_busy_done(n);
    check("b2b_rd_latency", 32'(n), 32'(2 + WAIT));
    @(negedge clk);
    check("b2b_we_low", 32'(we_lo), 32'(1 + WAIT));
    check("b2b_oe_low", 32'(oe_lo), 32'(1 + WAIT));
    check("b2b_rd_pulses", 32'(rdv_cnt), 32'd1);

    // req pulsed while busy must be dropped
    wait_ready();
    req = 1'b1; we = 1'b1; addr = 10'h055; wdata = 8'h77;
    @(posedge clk);
    #1;
    req = 1'b0;
    ref_mem[10'h055] = 8'h77;
    we_lo = 0; oe_lo = 0; rdv_cnt = 0;
    @(negedge clk);
    req = 1'b1; we = 1'b0; addr = 10'h066;
    @(posedge clk);
    #1;
    req = 1'b0;
    wait_busy_done(n);
    repeat (4) @(negedge clk);
    check("busy_we_low", 32'(we_lo), 32'(1 + WAIT));
    check("busy_oe_low", 32'(oe_lo), 32'd0);
    check("busy_rd_pulses", 32'(rdv_cnt), 32'd0);
    check("busy_ready", 32'(ready), 32'd1);
    access(1'b0, 10'h055, 8'h00);

    // Reset asserted during the write pulse
    @(negedge clk);
    wait_ready();
    req = 1'b1; we = 1'b1; addr = 10'h100; wdata = 8'hC3;
    @(posedge clk);
    #1;
    req = 1'b0;
    n = 0;
    while (sram_we_n && n < TMO) begin
      @(negedge clk);
      n++;
    end
    check("rst_mid_reached_pulse", 32'(sram_we_n), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_we_n", 32'(sram_we_n), 32'd1);
    check("rst_mid_drive", 32'(dut.drive_en), 32'd0);
    check("rst_mid_ready", 32'(ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    alt_ok = 1'b1;
    alt_val = 8'hC3;
    access(1'b0, 10'h100, 8'h00);
    check("rst_mid_rdata_known", 32'($isunknown(rdata)), 32'd0);
    access(1'b1, 10'h100, 8'h5A);

    // Randomized traffic over a small address pool plus the extremes
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 3))
        0: ra = '0;
        1: ra = '1;
        default: ra = ADDR_W'($urandom_range(0, 15));
      endcase
      access(1'($urandom_range(0, 1)), ra, DATA_W'($urandom));
    end

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
